// File: rtl/sub4b_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings
// and the default operand width.
package sub4b_serial_pkg;

  localparam int unsigned SUB4B_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub4b_serial_if.sv
// Start/done handshake and operand/result bus of the bit-serial subtractor.
// The signed-overflow flag V exists only when SUB4B_OVF_EN is defined.
interface sub4b_serial_if
  import sub4b_serial_pkg::*;
#(
  parameter int unsigned WIDTH = SUB4B_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] So;
  logic             Bo;
`ifdef SUB4B_OVF_EN
  logic             V;

  modport master (output start, A, B, input busy, done, So, Bo, V);
  modport slave  (input start, A, B, output busy, done, So, Bo, V);
`else
  modport master (output start, A, B, input busy, done, So, Bo);
  modport slave  (input start, A, B, output busy, done, So, Bo);
`endif

endinterface

// File: rtl/sub4b_serial_res1b.sv
// Combinational 1-bit full subtractor: D = A - B - Bi, Bo = borrow out.
module res1b (
  input  logic A,
  input  logic B,
  input  logic Bi,
  output logic D,
  output logic Bo
);

  assign D  = A ^ B ^ Bi;
  assign Bo = (~A & B) | (~(A ^ B) & Bi);

endmodule

// File: rtl/sub4b_serial.sv
// Bit-serial unsigned subtractor: So = (A - B) mod 2^WIDTH, Bo = (A < B),
// one bit per clock, LSB first, with a start/done handshake.
// Optional signed-overflow output V is enabled by defining SUB4B_OVF_EN.
module sub4b_serial
  import sub4b_serial_pkg::*;
#(
  parameter int unsigned WIDTH = SUB4B_WIDTH
) (
  input logic          clk,
  input logic          rst,
  sub4b_serial_if.slave bus
);

  localparam int unsigned    CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:1] res_sr;
  logic [WIDTH-1:0] res_nx;
  logic             borrow;
  logic [CW-1:0]    count;
  logic             accept;
  logic             last_bit;
  logic             d_bit;
  logic             bw_nx;
  logic [WIDTH-1:0] so_q;
  logic             bo_q;

  assign accept   = bus.start && (state != ST_RUN);
  assign last_bit = (count == LAST);

  res1b u_bit (
    .A  (a_sr[0]),
    .B  (b_sr[0]),
    .Bi (borrow),
    .D  (d_bit),
    .Bo (bw_nx)
  );

  // New difference bit enters from the MSB side; only the upper WIDTH-1
  // bits need storing because bit 0 of the shifter is never read back.
  assign res_nx = {d_bit, res_sr};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: RUN for WIDTH cycles, one DONE cycle, restartable from DONE.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (accept) state_nx = ST_RUN;
      ST_RUN:  if (last_bit) state_nx = ST_DONE;
      ST_DONE: state_nx = accept ? ST_RUN : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand shifters, borrow flip-flop, bit counter and partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      count  <= '0;
    end else if (accept) begin
      a_sr   <= bus.A;
      b_sr   <= bus.B;
      res_sr <= '0;
      borrow <= 1'b0;
      count  <= '0;
    end else if (state == ST_RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nx[WIDTH-1:1];
      borrow <= bw_nx;
      count  <= count + 1'b1;
    end
  end

  // Result registers update only on the final bit and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      so_q <= '0;
      bo_q <= 1'b0;
    end else if (state == ST_RUN && last_bit) begin
      so_q <= res_nx;
      bo_q <= bw_nx;
    end
  end

`ifdef SUB4B_OVF_EN
  logic v_q;

  // On the final bit the shifters present the latched operand MSBs at bit 0
  // and d_bit is So[MSB], so no extra copies of A/B MSBs are kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              v_q <= 1'b0;
    else if (state == ST_RUN && last_bit) v_q <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ d_bit);
  end

  assign bus.V = v_q;
`endif

  assign bus.busy = (state == ST_RUN);
  assign bus.done = (state == ST_DONE);
  assign bus.So   = so_q;
  assign bus.Bo   = bo_q;

endmodule
